mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter
//
// Purpose:
//   Shares one memory/peripheral port between an instruction-fetch requester
//   (I port, read-only) and a data requester (D port, loads and stores).
//   One transaction is in flight at a time. Each transaction walks through
//   IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> RESP -> IDLE. When both ports
//   ask at once, the port that did not win last time is served, so that
//   continuous contention alternates I, D, I, D.
//
// Parameters:
//   MEM_LAT   memory read latency in clock cycles (1..4)
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   rst       asynchronous, active-high reset
//   iReq      fetch request, held with stable iAddr until iAck
//   iAddr     fetch address
//   iAck      one-cycle pulse, iRdata valid
//   iRdata    fetched word, held until the next fetch completes
//   dReq      data request, held with stable dWe/dAddr/dWdata until dAck
//   dWe       1 = store, 0 = load
//   dAddr     data address
//   dWdata    store data
//   dAck      one-cycle pulse, access complete (dRdata valid for loads)
//   dRdata    loaded word, held until the next load completes
//   memAddr   address to the memory subsystem
//   memDin    write data to the memory subsystem
//   memWe     write enable, high for exactly the ACCESS cycle of a store
//   memDout   read data, valid MEM_LAT cycles after the address is presented
//   busy      high whenever the arbiter is not IDLE
// ============================================================================
module mem_bus_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        iReq,
    input  logic [31:0] iAddr,
    output logic        iAck,
    output logic [31:0] iRdata,

    input  logic        dReq,
    input  logic        dWe,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWdata,
    output logic        dAck,
    output logic [31:0] dRdata,

    output logic [31:0] memAddr,
    output logic [31:0] memDin,
    output logic        memWe,
    input  logic [31:0] memDout,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Terminal value of the WAIT counter; MEM_LAT of 1..4 fits in two bits.
    localparam logic [1:0] LAST_WAIT = 2'(MEM_LAT - 1);

    state_t     state;
    logic [1:0] wait_cnt;
    logic       last_grant;   // 0 = I port won last, 1 = D port won last
    logic       grant_d;      // current transaction belongs to the D port
    logic       grant_we;     // current transaction is a store
    logic       pick_d;       // arbitration result for this IDLE cycle

    // Arbitration: a lone requester always wins; under contention the port
    // that did not win the previous grant goes first.
    always_comb begin
        pick_d = 1'b0;
        if (iReq && dReq) begin
            pick_d = ~last_grant;
        end else if (dReq) begin
            pick_d = 1'b1;
        end
    end

    // Main transaction FSM. Every output is a register so the memory side
    // and both requesters see glitch-free, edge-aligned signals. Requests are
    // only looked at in IDLE, so changes during a transaction are ignored and
    // a grant always runs to completion unless reset intervenes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= 2'd0;
            last_grant <= 1'b0;
            grant_d    <= 1'b0;
            grant_we   <= 1'b0;
            iAck       <= 1'b0;
            dAck       <= 1'b0;
            iRdata     <= '0;
            dRdata     <= '0;
            memAddr    <= '0;
            memDin     <= '0;
            memWe      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iReq || dReq) begin
                        state      <= ACCESS;
                        busy       <= 1'b1;
                        last_grant <= pick_d;
                        grant_d    <= pick_d;
                        if (pick_d) begin
                            memAddr  <= dAddr;
                            memDin   <= dWdata;
                            memWe    <= dWe;
                            grant_we <= dWe;
                        end else begin
                            // Fetches never write, so no data goes to memory.
                            memAddr  <= iAddr;
                            memDin   <= '0;
                            memWe    <= 1'b0;
                            grant_we <= 1'b0;
                        end
                    end
                end

                ACCESS: begin
                    // The store strobe covers only the ACCESS cycle.
                    memWe    <= 1'b0;
                    wait_cnt <= 2'd0;
                    state    <= WAIT;
                end

                WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        wait_cnt <= 2'd0;
                        state    <= RESP;
                        // memDout is valid in the last WAIT cycle; stores
                        // leave the read-data registers untouched.
                        if (!grant_we) begin
                            if (grant_d) begin
                                dRdata <= memDout;
                            end else begin
                                iRdata <= memDout;
                            end
                        end
                        if (grant_d) begin
                            dAck <= 1'b1;
                        end else begin
                            iAck <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end

                RESP: begin
                    iAck  <= 1'b0;
                    dAck  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter
//
// Purpose:
//   Self-checking bench for mem_bus_arbiter. The bench plays both requesters
//   and the memory. Pending requests live in per-port queues; a transaction
//   level model decides which queued request is served, from which cycle it
//   was granted, and so which cycle each output must show which value.
//   A second instance with MEM_LAT = 3 gets a short directed load.
//
// Ports: none (top-level bench).
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int L = 1;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iReq = 1'b0;
    logic [31:0] iAddr = '0;
    logic        iAck;
    logic [31:0] iRdata;
    logic        dReq = 1'b0;
    logic        dWe = 1'b0;
    logic [31:0] dAddr = '0;
    logic [31:0] dWdata = '0;
    logic        dAck;
    logic [31:0] dRdata;
    logic [31:0] memAddr;
    logic [31:0] memDin;
    logic        memWe;
    logic [31:0] memDout = '0;
    logic        busy;

    logic        iReq2 = 1'b0;
    logic        iAck2;
    logic [31:0] iRdata2;
    logic        dReq2 = 1'b0;
    logic        dWe2 = 1'b0;
    logic [31:0] dAddr2 = '0;
    logic        dAck2;
    logic [31:0] dRdata2;
    logic [31:0] memAddr2;
    logic [31:0] memDin2;
    logic        memWe2;
    logic [31:0] memDout2 = '0;
    logic        busy2;

    int tests_run = 0;
    int tests_failed = 0;

    // Model state.
    txn_t        iq[$];
    txn_t        dq[$];
    txn_t        act;
    bit          active = 0;
    bit          act_d = 0;
    bit          last_d = 0;
    bit          in_reset = 1;
    bit          random_mode = 0;
    int          start_cyc = 0;
    int          cyc = 0;
    int          we_count = 0;
    logic [31:0] exp_ir = '0;
    logic [31:0] exp_dr = '0;
    int          ack_cyc[$];
    bit          ack_port[$];

    always #5 clk = ~clk;

    mem_bus_arbiter #(.MEM_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iRdata(iRdata),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
        .dAck(dAck), .dRdata(dRdata),
        .memAddr(memAddr), .memDin(memDin), .memWe(memWe), .memDout(memDout),
        .busy(busy)
    );

    mem_bus_arbiter #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .iReq(iReq2), .iAddr(32'h0), .iAck(iAck2), .iRdata(iRdata2),
        .dReq(dReq2), .dWe(dWe2), .dAddr(dAddr2), .dWdata(32'h0),
        .dAck(dAck2), .dRdata(dRdata2),
        .memAddr(memAddr2), .memDin(memDin2), .memWe(memWe2), .memDout(memDout2),
        .busy(busy2)
    );

    // One comparison: counts it, and reports tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic txn_t randTxn(input bit is_d);
        txn_t t;
        t.addr  = $urandom;
        t.we    = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
        t.wdata = $urandom;
        t.rdata = $urandom;
        return t;
    endfunction

    // Runs n cycles. In the middle of each cycle: check the outputs the model
    // predicts for this cycle, then drive requests and memory data for the
    // edge that ends it. A grant at cycle s means ACCESS at s+1, WAIT at
    // s+2..s+1+L, RESP (ack) at s+2+L.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            int  ph;
            bit  idle_now;
            bit  win_d;
            @(negedge clk);
            idle_now = !active;
            ph = active ? (cyc - start_cyc) : -1;

            checkOutput("busy", busy, active && ph >= 1 && ph <= L + 2);
            checkOutput("memWe", memWe, active && ph == 1 && act_d && act.we);
            checkOutput("iAck", iAck, active && ph == L + 2 && !act_d);
            checkOutput("dAck", dAck, active && ph == L + 2 && act_d);
            checkOutput("iRdata", iRdata, exp_ir);
            checkOutput("dRdata", dRdata, exp_dr);
            if (active && ph <= L + 1) begin
                checkOutput("memAddr", memAddr, act.addr);
                if (act_d) checkOutput("memDin", memDin, act.wdata);
            end
            if (iAck === 1'b1) begin ack_cyc.push_back(cyc); ack_port.push_back(1'b0); end
            if (dAck === 1'b1) begin ack_cyc.push_back(cyc); ack_port.push_back(1'b1); end
            if (memWe === 1'b1) we_count++;

            // Requester retires its request once the ack is seen.
            if (active && ph == L + 2) begin
                if (act_d) void'(dq.pop_front());
                else       void'(iq.pop_front());
                active = 0;
            end

            if (random_mode) begin
                if ($urandom_range(0, 3) == 0 && iq.size() < 2) iq.push_back(randTxn(1'b0));
                if ($urandom_range(0, 3) == 0 && dq.size() < 2) dq.push_back(randTxn(1'b1));
            end

            iReq   = iq.size() > 0;
            iAddr  = iReq ? iq[0].addr : $urandom;
            dReq   = dq.size() > 0;
            dWe    = dReq ? dq[0].we : 1'($urandom_range(0, 1));
            dAddr  = dReq ? dq[0].addr : $urandom;
            dWdata = dReq ? dq[0].wdata : $urandom;

            // Memory returns the word only in the last WAIT cycle; junk else.
            memDout = $urandom;
            if (active && ph == L + 1 && !(act_d && act.we)) begin
                memDout = act.rdata;
                if (act_d) exp_dr = act.rdata;
                else       exp_ir = act.rdata;
            end

            if (idle_now && !in_reset && (iReq || dReq)) begin
                if (iReq && dReq) win_d = !last_d;
                else              win_d = dReq;
                act_d     = win_d;
                act       = win_d ? dq[0] : iq[0];
                active    = 1;
                start_cyc = cyc;
                last_d    = win_d;
            end

            rst = in_reset;
            cyc++;
        end
    endtask

    task automatic runUntilIdle();
        int n = 0;
        while ((active || iq.size() > 0 || dq.size() > 0) && n < 200) begin
            applyStimulus(1);
            n++;
        end
        checkOutput("idle_timeout", 32'(n < 200), 32'd1);
    endtask

    task automatic resetModel();
        active = 0;
        last_d = 0;
        exp_ir = '0;
        exp_dr = '0;
    endtask

    // Two-cycle reset: the first cycle raises rst, the second checks zeros.
    task automatic doReset();
        in_reset = 1;
        applyStimulus(1);
        resetModel();
        applyStimulus(1);
        checkOutput("rst_memAddr", memAddr, 32'h0);
        checkOutput("rst_memDin", memDin, 32'h0);
        in_reset = 0;
    endtask

    task automatic clearLog();
        ack_cyc.delete();
        ack_port.delete();
        we_count = 0;
    endtask

    // Directed load on the MEM_LAT = 3 instance.
    task automatic lat3Test();
        logic [31:0] val;
        val = $urandom | 32'h1;
        @(negedge clk);
        dReq2 = 1'b1; dWe2 = 1'b0; dAddr2 = 32'h40; memDout2 = $urandom;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checkOutput("l3_busy", busy2, 32'(k <= 5));
            checkOutput("l3_dAck", dAck2, 32'(k == 5));
            checkOutput("l3_iAck", iAck2, 32'd0);
            checkOutput("l3_memWe", memWe2, 32'd0);
            checkOutput("l3_dRdata", dRdata2, (k >= 5) ? val : 32'h0);
            if (k <= 4) checkOutput("l3_memAddr", memAddr2, 32'h40);
            memDout2 = (k == 4) ? val : $urandom;
            if (k == 5) dReq2 = 1'b0;
        end
    endtask

    initial begin
        txn_t t;
        int   c0;
        logic [31:0] r0;
        logic [31:0] r1;

        // Power-on reset.
        resetModel();
        doReset();

        // Single fetch from 0x10.
        clearLog();
        t = randTxn(1'b0); t.addr = 32'h10; t.rdata = 32'hDEADBEEF;
        iq.push_back(t);
        c0 = cyc;
        runUntilIdle();
        checkOutput("fetch_ack_count", ack_cyc.size(), 1);
        if (ack_cyc.size() >= 1) begin
            checkOutput("fetch_ack_cycle", ack_cyc[0], c0 + 3);
            checkOutput("fetch_ack_port", ack_port[0], 0);
        end
        checkOutput("fetch_iRdata", iRdata, 32'hDEADBEEF);
        checkOutput("fetch_we_count", we_count, 0);

        // Single store to 0x20.
        clearLog();
        t.addr = 32'h20; t.we = 1'b1; t.wdata = 32'h55; t.rdata = $urandom;
        dq.push_back(t);
        c0 = cyc;
        runUntilIdle();
        checkOutput("store_ack_count", ack_cyc.size(), 1);
        if (ack_cyc.size() >= 1) begin
            checkOutput("store_ack_cycle", ack_cyc[0], c0 + 3);
            checkOutput("store_ack_port", ack_port[0], 1);
        end
        checkOutput("store_we_count", we_count, 1);
        checkOutput("store_dRdata", dRdata, 32'h0);

        // Contention straight out of reset: D first, then strict alternation.
        doReset();
        clearLog();
        for (int k = 0; k < 3; k++) begin
            iq.push_back(randTxn(1'b0));
            t = randTxn(1'b1); t.we = 1'b0;
            dq.push_back(t);
        end
        c0 = cyc;
        runUntilIdle();
        checkOutput("alt_ack_count", ack_cyc.size(), 6);
        if (ack_cyc.size() == 6) begin
            checkOutput("alt_first_cycle", ack_cyc[0], c0 + 3);
            for (int k = 0; k < 6; k++) begin
                checkOutput("alt_port", ack_port[k], (k % 2 == 0) ? 1 : 0);
                if (k > 0) checkOutput("alt_spacing", ack_cyc[k] - ack_cyc[k-1], 4);
            end
        end

        // Back-to-back fetches with the next address presented at ack.
        clearLog();
        iq.push_back(randTxn(1'b0));
        iq.push_back(randTxn(1'b0));
        c0 = cyc;
        runUntilIdle();
        checkOutput("b2b_ack_count", ack_cyc.size(), 2);
        if (ack_cyc.size() == 2) begin
            checkOutput("b2b_first", ack_cyc[0], c0 + 3);
            checkOutput("b2b_second", ack_cyc[1], c0 + 7);
        end

        // Random traffic on both ports.
        random_mode = 1;
        applyStimulus(400);
        random_mode = 0;
        runUntilIdle();

        // Reset during WAIT of a load aborts it; the held load is re-served.
        r0 = $urandom | 32'h1;
        t = randTxn(1'b1); t.we = 1'b0; t.rdata = r0;
        dq.push_back(t);
        runUntilIdle();
        checkOutput("pre_rst_dRdata", dRdata, r0);
        r1 = $urandom | 32'h1;
        t = randTxn(1'b1); t.we = 1'b0; t.rdata = r1;
        dq.push_back(t);
        applyStimulus(2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 32'd0);
        checkOutput("midrst_dAck", dAck, 32'd0);
        checkOutput("midrst_dRdata", dRdata, 32'h0);
        checkOutput("midrst_memWe", memWe, 32'd0);
        cyc++;
        resetModel();
        in_reset = 1;
        applyStimulus(1);
        in_reset = 0;
        clearLog();
        c0 = cyc;
        runUntilIdle();
        checkOutput("rerun_ack_count", ack_cyc.size(), 1);
        if (ack_cyc.size() >= 1) begin
            checkOutput("rerun_ack_cycle", ack_cyc[0], c0 + 3);
            checkOutput("rerun_ack_port", ack_port[0], 1);
        end
        checkOutput("rerun_dRdata", dRdata, r1);

        // Longer memory latency.
        lat3Test();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
